lc3_mem_ctrl: RTL and testbench

- Memory/IO access stage between the LC-3 control FSM and external memory.
- Owns MAR and MDR. Consumes the control word's LD.MAR, LD.MDR, MIO.EN, R.W and GateMDR fields.
- Runs a req/ack handshake to external memory and returns the one-cycle ready flag R that releases the FSM from its wait states (fetch, LD, LDI, STI, ST, TRAP).
- Optionally decodes the LC-3 memory-mapped keyboard/display registers.

---
 rtl/lc3_pkg.sv | 20 ++
 rtl/lc3_mmio_regs.sv | 77 +++++++
 rtl/lc3_mem_ctrl.sv | 122 ++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 memory/IO access stage.
// The MMIO register block is built only when LC3_MMIO_EN is defined.
package lc3_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;

    // Memory-mapped keyboard/display register addresses
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lc3_mmio_regs.sv
// LC-3 keyboard/display registers (KBSR, KBDR, DSR, DDR) and their address decode.
// Compiled only when LC3_MMIO_EN is defined.
`ifdef LC3_MMIO_EN
module lc3_mmio_regs
    import lc3_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              access,
    input  logic              we,
    input  logic              kbd_valid,
    input  logic [7:0]        kbd_data,
    input  logic              disp_ack,
    output logic              hit,
    output logic [DATA_W-1:0] rdata,
    output logic              disp_valid,
    output logic [7:0]        disp_data
);

    logic       sel_kbsr, sel_kbdr, sel_dsr, sel_ddr;
    logic       kbd_ready;
    logic [7:0] kbdr;
    logic       dsr_ready;
    logic       rd_kbdr, wr_ddr;

    assign sel_kbsr = (addr == ADDR_W'(KBSR_ADDR));
    assign sel_kbdr = (addr == ADDR_W'(KBDR_ADDR));
    assign sel_dsr  = (addr == ADDR_W'(DSR_ADDR));
    assign sel_ddr  = (addr == ADDR_W'(DDR_ADDR));
    assign hit      = sel_kbsr | sel_kbdr | sel_dsr | sel_ddr;

    assign rd_kbdr  = access & ~we & sel_kbdr;
    assign wr_ddr   = access &  we & sel_ddr;

    // Status/data registers; a new keystroke outranks the KBDR read that would clear ready
    always_ff @(posedge clk) begin
        if (!rst) begin
            kbd_ready  <= 1'b0;
            kbdr       <= '0;
            dsr_ready  <= 1'b1;
            disp_valid <= 1'b0;
            disp_data  <= '0;
        end else begin
            disp_valid <= wr_ddr;
            if (wr_ddr)
                disp_data <= wdata[7:0];
            if (kbd_valid) begin
                kbd_ready <= 1'b1;
                kbdr      <= kbd_data;
            end else if (rd_kbdr) begin
                kbd_ready <= 1'b0;
            end
            if (disp_ack)
                dsr_ready <= 1'b1;
            else if (wr_ddr)
                dsr_ready <= 1'b0;
        end
    end

    // Read-data mux for the selected register
    always_comb begin
        rdata = '0;
        if (sel_kbsr)
            rdata[DATA_W-1] = kbd_ready;
        else if (sel_kbdr)
            rdata[7:0] = kbdr;
        else if (sel_dsr)
            rdata[DATA_W-1] = dsr_ready;
    end

endmodule
`endif

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory/IO access stage: owns MAR/MDR, runs req/ack to external memory
// and returns the one-cycle ready pulse R to the control FSM.
// Define LC3_MMIO_EN to serve xFE00-xFE06 (keyboard/display) internally.
module lc3_mem_ctrl
    import lc3_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              mio_en,
    input  logic              r_w,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] mdr_out,
    output logic              R,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef LC3_MMIO_EN
    ,
    input  logic              kbd_valid,
    input  logic [7:0]        kbd_data,
    output logic              disp_valid,
    output logic [7:0]        disp_data,
    input  logic              disp_ack
`endif
);

    state_t            state, next;
    logic [ADDR_W-1:0] mar, addr_q;
    logic [DATA_W-1:0] mdr, wdata_q;
    logic              we_q;
    logic              start;
    logic              mmio_hit;
    logic [DATA_W-1:0] mmio_rdata;

    assign start = (state == IDLE) && mio_en;

`ifdef LC3_MMIO_EN
    lc3_mmio_regs #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mmio (
        .clk        (clk),
        .rst        (rst),
        .addr       (mar),
        .wdata      (mdr),
        .access     (start),
        .we         (r_w),
        .kbd_valid  (kbd_valid),
        .kbd_data   (kbd_data),
        .disp_ack   (disp_ack),
        .hit        (mmio_hit),
        .rdata      (mmio_rdata),
        .disp_valid (disp_valid),
        .disp_data  (disp_data)
    );
`else
    assign mmio_hit   = 1'b0;
    assign mmio_rdata = '0;
`endif

    // State, MAR/MDR and the request snapshot taken when an access starts
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            mar     <= '0;
            mdr     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state <= next;
            if (ld_mar)
                mar <= ADDR_W'(bus_in);
            if (start) begin
                we_q    <= r_w;
                addr_q  <= mar;
                wdata_q <= mdr;
            end
            if ((state == REQ) && mem_ack && !we_q && ld_mdr)
                mdr <= mem_rdata;
            else if (start && mmio_hit && !r_w && ld_mdr)
                mdr <= mmio_rdata;
            else if (ld_mdr && !mio_en)
                mdr <= bus_in;
        end
    end

    // Next-state and handshake outputs; R is a decode of the DONE state register
    always_comb begin
        next    = state;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        R       = 1'b0;
        unique case (state)
            IDLE: if (mio_en) next = mmio_hit ? DONE : REQ;
            REQ: begin
                mem_req = 1'b1;
                mem_we  = we_q;
                if (mem_ack) next = DONE;
            end
            DONE: begin
                R    = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // Address/data held from the snapshot while a request is outstanding
    assign mem_addr  = (state == REQ) ? addr_q  : mar;
    assign mem_wdata = (state == REQ) ? wdata_q : mdr;
    assign mdr_out   = mdr;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl; MMIO scenario runs when LC3_MMIO_EN is defined.
module tb_lc3_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_mar, ld_mdr, mio_en, r_w;
    logic [15:0] bus_in, mdr_out, mem_addr, mem_wdata, mem_rdata;
    logic        R, mem_req, mem_we, mem_ack;
`ifdef LC3_MMIO_EN
    logic        kbd_valid, disp_valid, disp_ack;
    logic [7:0]  kbd_data, disp_data;
    int          dv_count = 0;
    logic [7:0]  dv_data = '0;
`endif

    int          checks = 0;
    int          failures = 0;
    int          req_mon = 0;
    logic [15:0] m_mar, m_mdr;

    always #5 clk = ~clk;

    lc3_mem_ctrl #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mio_en(mio_en), .r_w(r_w),
        .bus_in(bus_in), .mdr_out(mdr_out), .R(R), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef LC3_MMIO_EN
        , .kbd_valid(kbd_valid), .kbd_data(kbd_data), .disp_valid(disp_valid),
        .disp_data(disp_data), .disp_ack(disp_ack)
`endif
    );

    always @(negedge clk) begin
        if (mem_req === 1'b1) req_mon++;
`ifdef LC3_MMIO_EN
        if (disp_valid === 1'b1) begin
            dv_count++;
            dv_data = disp_data;
        end
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mar(input logic [15:0] v);
        ld_mar = 1'b1; bus_in = v;
        tick();
        ld_mar = 1'b0;
        m_mar = v;
    endtask

    task automatic set_mdr(input logic [15:0] v);
        ld_mdr = 1'b1; mio_en = 1'b0; bus_in = v;
        tick();
        ld_mdr = 1'b0;
        m_mdr = v;
    endtask

    // Drives one access with ack on the n-th request cycle; reports what was seen.
    task automatic access(input logic we, input logic [15:0] rdata, input int n,
                          input bit poke, input bit drop,
                          output int req_cycles, output int r_cycles, output int lat,
                          output logic [15:0] first_addr, output bit addr_stable,
                          output logic seen_we, output logic [15:0] seen_wdata);
        req_cycles = 0; r_cycles = 0; lat = -1; first_addr = '0;
        addr_stable = 1'b1; seen_we = 1'b0; seen_wdata = '0;
        mio_en = 1'b1; r_w = we; ld_mdr = !we; mem_rdata = rdata;
        tick();
        for (int i = 0; i < 40; i++) begin
            if (R === 1'b1) begin
                r_cycles++;
                lat = i;
                break;
            end
            if (mem_req === 1'b1) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    first_addr = mem_addr; seen_we = mem_we; seen_wdata = mem_wdata;
                end else if (mem_addr !== first_addr) begin
                    addr_stable = 1'b0;
                end
            end
            mem_ack = (mem_req === 1'b1) && (req_cycles == n);
            if (poke && req_cycles == 1) begin
                ld_mar = 1'b1;
                bus_in = 16'($urandom_range(0, 16'hFDFF));
                m_mar  = bus_in;
            end
            if (drop && req_cycles >= 1) mio_en = 1'b0;
            tick();
            mem_ack = 1'b0; ld_mar = 1'b0;
        end
        mio_en = 1'b0; ld_mdr = 1'b0; r_w = 1'b0;
        tick();
        if (R === 1'b1) r_cycles++;
        if (mem_req === 1'b1) req_cycles++;
        if (!we) m_mdr = rdata;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0; bus_in = '0; mem_rdata = '0; mem_ack = 0;
`ifdef LC3_MMIO_EN
        kbd_valid = 0; kbd_data = '0; disp_ack = 0;
`endif
        tick(); tick();
        checks++; if (mdr_out !== 16'h0) begin failures++; $display("FAIL reset_mdr got=%h exp=0000", mdr_out); end
        checks++; if (mem_addr !== 16'h0) begin failures++; $display("FAIL reset_mar got=%h exp=0000", mem_addr); end
        checks++; if ({R, mem_req, mem_we} !== 3'b000) begin failures++; $display("FAIL reset_ctl got=%b exp=000", {R, mem_req, mem_we}); end
        rst = 1'b1;
        tick();
        m_mar = '0; m_mdr = '0;
    endtask

    task automatic test_read();
        int rq, rc, lt; logic [15:0] fa, wd; bit st; logic w;
        set_mar(16'h3000);
        access(1'b0, 16'h1234, 3, 1'b0, 1'b0, rq, rc, lt, fa, st, w, wd);
        checks++; if (rq !== 3) begin failures++; $display("FAIL read_req_cycles got=%0d exp=3", rq); end
        checks++; if (fa !== 16'h3000) begin failures++; $display("FAIL read_addr got=%h exp=3000", fa); end
        checks++; if (w !== 1'b0) begin failures++; $display("FAIL read_we got=%b exp=0", w); end
        checks++; if (rc !== 1 || lt !== 3) begin failures++; $display("FAIL read_r got=%0d lat=%0d exp=1 lat=3", rc, lt); end
        checks++; if (mdr_out !== 16'h1234) begin failures++; $display("FAIL read_mdr got=%h exp=1234", mdr_out); end
    endtask

    task automatic test_write();
        int rq, rc, lt; logic [15:0] fa, wd; bit st; logic w;
        set_mar(16'h4000);
        set_mdr(16'hBEEF);
        access(1'b1, 16'h5555, 1, 1'b0, 1'b0, rq, rc, lt, fa, st, w, wd);
        checks++; if (rq !== 1) begin failures++; $display("FAIL write_req_cycles got=%0d exp=1", rq); end
        checks++; if ({w, fa, wd} !== {1'b1, 16'h4000, 16'hBEEF}) begin failures++; $display("FAIL write_bus got=%b/%h/%h exp=1/4000/beef", w, fa, wd); end
        checks++; if (rc !== 1 || lt !== 1) begin failures++; $display("FAIL write_r got=%0d lat=%0d exp=1 lat=1", rc, lt); end
        checks++; if (mdr_out !== 16'hBEEF) begin failures++; $display("FAIL write_mdr got=%h exp=beef", mdr_out); end
    endtask

    task automatic test_back_to_back();
        int rq, rc, lt, pulses; logic [15:0] fa, wd; bit st; logic w;
        pulses = 0;
        set_mar(16'h3000);
        access(1'b0, 16'hA000, 2, 1'b0, 1'b0, rq, rc, lt, fa, st, w, wd);
        pulses += rc;
        set_mar(m_mdr);
        access(1'b0, 16'h0042, 1, 1'b0, 1'b0, rq, rc, lt, fa, st, w, wd);
        pulses += rc;
        checks++; if (fa !== 16'hA000) begin failures++; $display("FAIL b2b_addr got=%h exp=a000", fa); end
        checks++; if (pulses !== 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
        checks++; if (mdr_out !== 16'h0042) begin failures++; $display("FAIL b2b_mdr got=%h exp=0042", mdr_out); end
    endtask

    task automatic test_reset_mid_req();
        set_mar(16'h1111);
        set_mdr(16'h2222);
        mio_en = 1'b1; r_w = 1'b0;
        tick();
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL midreq_req_high got=%b exp=1", mem_req); end
        rst = 1'b0; mio_en = 1'b0;
        tick();
        checks++; if ({mem_req, R} !== 2'b00) begin failures++; $display("FAIL midreq_ctl got=%b exp=00", {mem_req, R}); end
        checks++; if ({mem_addr, mdr_out} !== 32'h0) begin failures++; $display("FAIL midreq_regs got=%h/%h exp=0000/0000", mem_addr, mdr_out); end
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        tick();
        mem_ack = 1'b0;
        tick();
        checks++; if ({mem_req, R, mdr_out} !== 18'h0) begin failures++; $display("FAIL stray_ack got=%b/%b/%h exp=0/0/0000", mem_req, R, mdr_out); end
        m_mar = '0; m_mdr = '0;
    endtask

    task automatic test_random();
        int rq, rc, lt, n; logic [15:0] fa, wd, addr, data, exp_addr, exp_wd; bit st, poke, drop; logic w, we;
        for (int t = 0; t < 24; t++) begin
            addr = 16'($urandom_range(0, 16'hFDFF));
            data = 16'($urandom);
            we   = 1'($urandom_range(0, 1));
            n    = int'($urandom_range(1, 4));
            poke = 1'($urandom_range(0, 1));
            drop = 1'($urandom_range(0, 1));
            set_mar(addr);
            if (we) set_mdr(data);
            exp_addr = m_mar; exp_wd = m_mdr;
            access(we, data, n, poke, drop, rq, rc, lt, fa, st, w, wd);
            checks++;
            if (rq !== n || rc !== 1 || lt !== n || fa !== exp_addr || !st || w !== we ||
                (we && wd !== exp_wd) || mdr_out !== m_mdr || mem_addr !== m_mar) begin
                failures++;
                $display("FAIL rand_%0d req=%0d/%0d r=%0d lat=%0d addr=%h/%h stable=%0d we=%b/%b wd=%h/%h mdr=%h/%h mar=%h/%h",
                         t, rq, n, rc, lt, fa, exp_addr, st, w, we, wd, exp_wd, mdr_out, m_mdr, mem_addr, m_mar);
            end
        end
    endtask

`ifdef LC3_MMIO_EN
    task automatic mmio_read(input logic [15:0] a, input logic [15:0] exp, input string name);
        int rq, rc, lt; logic [15:0] fa, wd; bit st; logic w;
        set_mar(a);
        access(1'b0, 16'hDEAD, 1, 1'b0, 1'b0, rq, rc, lt, fa, st, w, wd);
        checks++;
        if (mdr_out !== exp || rq !== 0 || rc !== 1 || lt !== 0) begin
            failures++;
            $display("FAIL %s mdr=%h exp=%h req=%0d r=%0d lat=%0d exp req=0 r=1 lat=0", name, mdr_out, exp, rq, rc, lt);
        end
    endtask

    task automatic test_mmio();
        int rq, rc, lt; logic [15:0] fa, wd; bit st; logic w;
        req_mon = 0;
        kbd_valid = 1'b1; kbd_data = 8'h41;
        tick();
        kbd_valid = 1'b0;
        mmio_read(16'hFE00, 16'h8000, "kbsr_set");
        mmio_read(16'hFE02, 16'h0041, "kbdr");
        mmio_read(16'hFE00, 16'h0000, "kbsr_clr");
        set_mdr(16'h0058);
        set_mar(16'hFE06);
        dv_count = 0;
        access(1'b1, 16'h0, 1, 1'b0, 1'b0, rq, rc, lt, fa, st, w, wd);
        checks++; if (dv_count !== 1 || dv_data !== 8'h58) begin failures++; $display("FAIL ddr_write pulses=%0d data=%h exp=1/58", dv_count, dv_data); end
        mmio_read(16'hFE04, 16'h0000, "dsr_busy");
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
        mmio_read(16'hFE04, 16'h8000, "dsr_ready");
        checks++; if (req_mon !== 0) begin failures++; $display("FAIL mmio_no_req got=%0d exp=0", req_mon); end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_reset_mid_req();
        test_random();
`ifdef LC3_MMIO_EN
        test_mmio();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
